// File: rtl/off_chip_nibble_rx.sv
// off_chip_nibble_rx
//   Receives 4-bit nibbles from an off-chip transmitter over a credit-based
//   link, buffers them in a DEPTH-entry FIFO and reassembles pairs of
//   nibbles into bytes for a valid/ready consumer.
//
//   Parameters:
//     DEPTH       buffer entries (power of two, 2..16)
//
//   Ports:
//     clk         clock, rising edge
//     rst         synchronous, active-high reset
//     link_data   nibble from the transmitter
//     link_valid  link_data valid this cycle (no ready: credit flow control)
//     link_parity even parity of link_data (OFF_CHIP_RX_PARITY_EN only)
//     credit_ret  one-cycle pulse per popped nibble, returns one credit
//     data_out    reassembled byte
//     valid_out   data_out holds a valid byte
//     ready       consumer accepts data_out when valid_out && ready
//     occupancy   buffer entries in use, 0..DEPTH
//     overflow    sticky: a nibble arrived while the buffer was full
//     parity_err  sticky: a popped nibble failed parity (OFF_CHIP_RX_PARITY_EN only)
//     state_dbg   reassembly FSM state (0=LO, 1=HI, 2=OUT)
//
//   Handshake: a byte transfers on a rising edge where valid_out and ready
//   are both high; data_out is held stable while valid_out && !ready.
//
//   Optional feature macro: OFF_CHIP_RX_PARITY_EN adds per-nibble parity
//   storage and checking.
module off_chip_nibble_rx #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [3:0]               link_data,
  input  logic                     link_valid,
`ifdef OFF_CHIP_RX_PARITY_EN
  input  logic                     link_parity,
  output logic                     parity_err,
`endif
  output logic                     credit_ret,
  output logic [7:0]               data_out,
  output logic                     valid_out,
  input  logic                     ready,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     overflow,
  output logic [1:0]               state_dbg
);

  localparam int AW = $clog2(DEPTH);
`ifdef OFF_CHIP_RX_PARITY_EN
  localparam int EW = 5;
`else
  localparam int EW = 4;
`endif

  typedef enum logic [1:0] {
    ST_LO  = 2'd0,
    ST_HI  = 2'd1,
    ST_OUT = 2'd2
  } state_t;

  state_t        state;
  logic [EW-1:0] mem [DEPTH];
  logic [AW:0]   wptr, rptr;
  logic [AW:0]   wptr_nxt, rptr_nxt;
  logic [3:0]    lo_reg;
  logic [EW-1:0] rd_entry;
  logic [EW-1:0] wr_entry;
  logic          full, empty, wr_en, pop;

  // Pointers carry one extra wrap bit: equal means empty, differing only in
  // the wrap bit means full. Both flags come from registered pointers, so
  // fullness is the value at the start of the cycle.
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty = (wptr == rptr);
  assign wr_en = link_valid && !full;

  assign rd_entry  = mem[rptr[AW-1:0]];
  assign state_dbg = state;

`ifdef OFF_CHIP_RX_PARITY_EN
  assign wr_entry = {link_parity, link_data};
`else
  assign wr_entry = link_data;
`endif

  // At most one pop per cycle, decided by the FSM state.
  always_comb begin
    pop = 1'b0;
    case (state)
      ST_LO:   pop = !empty;
      ST_HI:   pop = !empty;
      ST_OUT:  pop = ready && !empty;
      default: pop = 1'b0;
    endcase
  end

  assign wptr_nxt = wptr + {{AW{1'b0}}, wr_en};
  assign rptr_nxt = rptr + {{AW{1'b0}}, pop};

  // Storage has no reset; contents are discarded by resetting the pointers.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) mem[wptr[AW-1:0]] <= wr_entry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr       <= '0;
      rptr       <= '0;
      occupancy  <= '0;
      state      <= ST_LO;
      lo_reg     <= 4'h0;
      data_out   <= 8'h00;
      valid_out  <= 1'b0;
      credit_ret <= 1'b0;
      overflow   <= 1'b0;
`ifdef OFF_CHIP_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      wptr       <= wptr_nxt;
      rptr       <= rptr_nxt;
      // Registered copy of wptr - rptr after this edge's write and pop.
      occupancy  <= wptr_nxt - rptr_nxt;
      credit_ret <= pop;
      // A nibble into a full buffer is lost even if a pop frees space now.
      if (link_valid && full) overflow <= 1'b1;
`ifdef OFF_CHIP_RX_PARITY_EN
      if (pop && ((^rd_entry[3:0]) != rd_entry[4])) parity_err <= 1'b1;
`endif
      case (state)
        ST_LO: begin
          if (!empty) begin
            lo_reg <= rd_entry[3:0];
            state  <= ST_HI;
          end
        end
        ST_HI: begin
          if (!empty) begin
            // First nibble {b5,b4,b1,b0}, second nibble {b7,b6,b3,b2}.
            data_out  <= {rd_entry[3:2], lo_reg[3:2], rd_entry[1:0], lo_reg[1:0]};
            valid_out <= 1'b1;
            state     <= ST_OUT;
          end
        end
        ST_OUT: begin
          if (ready) begin
            valid_out <= 1'b0;
            if (!empty) begin
              lo_reg <= rd_entry[3:0];
              state  <= ST_HI;
            end else begin
              state <= ST_LO;
            end
          end
        end
        default: state <= ST_LO;
      endcase
    end
  end

endmodule

// File: tb/tb_off_chip_nibble_rx.sv
// tb_off_chip_nibble_rx
//   Directed bench for off_chip_nibble_rx. Drivers issue nibbles and push
//   the expected bytes into exp_q; a monitor on the falling edge pops and
//   compares every accepted byte, checks data_out stability under
//   backpressure and counts credit_ret pulses.
module tb_off_chip_nibble_rx;

  localparam int DEPTH = 8;
  localparam int OW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    link_data;
  logic          link_valid;
  logic          credit_ret;
  logic [7:0]    data_out;
  logic          valid_out;
  logic          ready;
  logic [OW-1:0] occupancy;
  logic          overflow;
  logic [1:0]    state_dbg;
`ifdef OFF_CHIP_RX_PARITY_EN
  logic          link_parity;
  logic          parity_err;
`endif

  off_chip_nibble_rx #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .link_data  (link_data),
    .link_valid (link_valid),
`ifdef OFF_CHIP_RX_PARITY_EN
    .link_parity(link_parity),
    .parity_err (parity_err),
`endif
    .credit_ret (credit_ret),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .ready      (ready),
    .occupancy  (occupancy),
    .overflow   (overflow),
    .state_dbg  (state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int         checks = 0;
  int         errors = 0;
  int         credit_cnt = 0;
  logic [7:0] exp_q[$];
  logic       hold_prev = 1'b0;
  logic [7:0] hold_data = 8'h00;

  localparam logic [1:0] S_LO = 2'd0, S_HI = 2'd1, S_OUT = 2'd2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] decode(input logic [3:0] n0, input logic [3:0] n1);
    return {n1[3:2], n0[3:2], n1[1:0], n0[1:0]};
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [7:0] e;
    if (credit_ret) credit_cnt++;
    if (!rst && valid_out) begin
      if (hold_prev) chk("data_out_stable", data_out, hold_data);
      if (ready) begin
        hold_prev = 1'b0;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got 0x%0h expected none", data_out);
        end else begin
          e = exp_q.pop_front();
          chk("byte", data_out, e);
        end
      end else begin
        hold_prev = 1'b1;
        hold_data = data_out;
      end
    end else begin
      hold_prev = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [3:0] n, input logic bad_par = 1'b0);
    link_valid = 1'b1;
    link_data  = n;
`ifdef OFF_CHIP_RX_PARITY_EN
    link_parity = bad_par ? ~(^n) : (^n);
`else
    if (bad_par) link_data = n;
`endif
    tick();
  endtask

  task automatic idle(input int n);
    link_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    link_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 100; i++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    chk({"drain_", name}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int         base;
    logic [3:0] prev;
    logic [3:0] cur;

    rst        = 1'b1;
    link_valid = 1'b0;
    link_data  = 4'h0;
    ready      = 1'b0;
`ifdef OFF_CHIP_RX_PARITY_EN
    link_parity = 1'b0;
`endif
    tick();
    tick();
    // Reset state
    chk("rst_data_out", data_out, 8'h00);
    chk("rst_valid_out", valid_out, 0);
    chk("rst_credit_ret", credit_ret, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_occupancy", occupancy, 0);
    chk("rst_state", state_dbg, S_LO);
`ifdef OFF_CHIP_RX_PARITY_EN
    chk("rst_parity_err", parity_err, 0);
`endif
    rst = 1'b0;
    tick();

    // Basic decode: 0xC then 0x3 -> 0x3C, two credits
    ready = 1'b1;
    base  = credit_cnt;
    exp_q.push_back(8'h3C);
    send(4'hC);
    send(4'h3);
    idle(5);
    wait_drain("basic");
    chk("basic_credits", credit_cnt - base, 2);

    // Backpressure and overflow: 11 nibbles with ready low
    ready = 1'b0;
    base  = credit_cnt;
    exp_q.push_back(8'h09);
    for (int i = 2; i < 10; i += 2)
      exp_q.push_back(decode(4'(i + 1), 4'(i + 2)));
    for (int i = 0; i < 11; i++) send(4'(i + 1));
    link_valid = 1'b0;
    chk("bp_occupancy", occupancy, DEPTH);
    chk("bp_overflow", overflow, 1);
    chk("bp_valid_out", valid_out, 1);
    chk("bp_first_byte", data_out, 8'h09);
    idle(4);
    ready = 1'b1;
    wait_drain("backpressure");
    idle(3);
    chk("bp_credits", credit_cnt - base, 10);
    chk("bp_overflow_sticky", overflow, 1);
    chk("bp_occupancy_drained", occupancy, 0);
    do_reset();
    chk("bp_overflow_cleared", overflow, 0);

    // Credit accounting: 40 nibbles streamed with ready high
    ready = 1'b1;
    base  = credit_cnt;
    prev  = 4'h0;
    for (int i = 0; i < 40; i++) begin
      cur = 4'((i * 7 + 3) & 15);
      if (i % 2 == 1) exp_q.push_back(decode(prev, cur));
      prev = cur;
      send(cur);
    end
    idle(4);
    wait_drain("stream");
    idle(2);
    chk("stream_credits", credit_cnt - base, 40);
    chk("stream_overflow", overflow, 0);
    chk("stream_occupancy", occupancy, 0);

    // Simultaneous pop and write in OUT
    ready = 1'b0;
    exp_q.push_back(8'h66);
    exp_q.push_back(8'hDA);
    send(4'hA);
    send(4'h5);
    send(4'h6);
    chk("sim_state_out", state_dbg, S_OUT);
    chk("sim_occ_before", occupancy, 1);
    ready = 1'b1;
    send(4'hE);
    chk("sim_occ_after", occupancy, 1);
    chk("sim_state_hi", state_dbg, S_HI);
    idle(4);
    wait_drain("simultaneous");

    // Reset mid-operation in HI with occupancy 3
    idle(2);
    ready = 1'b0;
    base  = credit_cnt;
    exp_q.push_back(8'h09);
    for (int i = 0; i < 6; i++) send(4'(i + 1));
    link_valid = 1'b0;
    ready = 1'b1;
    tick();
    chk("midrst_state_hi", state_dbg, S_HI);
    chk("midrst_occ3", occupancy, 3);
    rst        = 1'b1;
    link_valid = 1'b1;
    link_data  = 4'hF;
    tick();
    rst        = 1'b0;
    link_valid = 1'b0;
    chk("midrst_valid_out", valid_out, 0);
    chk("midrst_occupancy", occupancy, 0);
    chk("midrst_state_lo", state_dbg, S_LO);
    chk("midrst_credit_ret", credit_ret, 0);
    wait_drain("midrst_first");
    exp_q.push_back(8'hA5);
    send(4'h9);
    send(4'h9);
    idle(4);
    wait_drain("midrst_a5");
    idle(2);
    chk("midrst_credits", credit_cnt - base, 5);

`ifdef OFF_CHIP_RX_PARITY_EN
    // Parity: a wrong-parity nibble flags the error but the byte still arrives
    ready = 1'b1;
    chk("par_err_clear", parity_err, 0);
    exp_q.push_back(8'h1D);
    send(4'h5);
    send(4'h3, 1'b1);
    idle(4);
    wait_drain("parity");
    chk("par_err_set", parity_err, 1);
`endif

    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
